// File: rtl/mmio_io_if.sv
// CPU-side I/O window bus between the memory/IO bridge and the I/O responder.
interface mmio_io_if;
    logic [15:0] io_addr;
    logic [15:0] io_data_out;
    logic        io_we;
    logic [15:0] io_data_in;

    modport master (
        output io_addr,
        output io_data_out,
        output io_we,
        input  io_data_in
    );

    modport slave (
        input  io_addr,
        input  io_data_out,
        input  io_we,
        output io_data_in
    );
endinterface

// File: rtl/mmio_io_responder.sv
// I/O window responder: LED, synchronized switches, UART TX with byte FIFO, status register.
// Reads are combinational from io_addr[13:0]; writes commit on the rising clock edge.
// Optional millisecond timer at 0x0004 is built only when IO_TIMER_EN is defined.
module mmio_io_responder #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    mmio_io_if.slave    io,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic        uart_txd_o
);
    localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
    localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    // Address decode; the two top bits of the window offset are ignored
    logic [13:0] addr;
    logic        unused_addr;
    assign addr        = io.io_addr[13:0];
    assign unused_addr = ^io.io_addr[15:14];

    logic sel_led, sel_tx, sel_status;
    assign sel_led    = (addr == 14'h0000);
    assign sel_tx     = (addr == 14'h0002);
    assign sel_status = (addr == 14'h0003);

    logic [15:0] led_q;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic        ovf_q;
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    tx_state_e       state_q, state_d;
    logic [CntW-1:0] baud_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            busy, full, empty, push, pop, bit_done, wr_tx;

    assign full     = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign wr_tx    = io.io_we && sel_tx;
    assign push     = wr_tx && !full;
    // A pop in the same cycle does not rescue a write to a full FIFO
    assign pop      = (state_q == StIdle) && !empty;
    assign bit_done = (baud_cnt_q == CntW'(ClksPerBit - 1));

    // FIFO occupancy next-state
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers, switch synchronizer and FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
            if (io.io_we && sel_led) led_q <= io.io_data_out;
            if (wr_tx && full) ovf_q <= 1'b1;
            else if (io.io_we && sel_status) ovf_q <= 1'b0;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= io.io_data_out[7:0];
    end

    // TX FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // TX FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!empty) state_d = StStart;
            StStart: if (bit_done) state_d = StData;
            StData:  if (bit_done && bit_idx_q == 3'd7) state_d = StStop;
            StStop:  if (bit_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // TX FSM outputs; line level is decoded from state so reset forces it high at once
    always_comb begin
        uart_txd_o = 1'b1;
        busy       = (state_q != StIdle);
        unique case (state_q)
            StStart: uart_txd_o = 1'b0;
            StData:  uart_txd_o = shift_q[0];
            default: uart_txd_o = 1'b1;
        endcase
    end

    // Bit timing, bit index and shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else if (pop) begin
            shift_q    <= fifo_mem[rd_ptr_q];
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
        end else if (state_q != StIdle) begin
            if (bit_done) begin
                baud_cnt_q <= '0;
                if (state_q == StData) begin
                    shift_q   <= shift_q >> 1;
                    bit_idx_q <= bit_idx_q + 1'b1;
                end
            end else begin
                baud_cnt_q <= baud_cnt_q + 1'b1;
            end
        end
    end

`ifdef IO_TIMER_EN
    localparam int unsigned TicksPerMs = CLK_HZ / 1000;
    localparam int unsigned PreW = (TicksPerMs > 1) ? $clog2(TicksPerMs) : 1;
    logic [PreW-1:0] pre_q;
    logic [15:0]     timer_q;

    // Millisecond counter; any write to its address restarts both stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            timer_q <= '0;
        end else if (io.io_we && addr == 14'h0004) begin
            pre_q   <= '0;
            timer_q <= '0;
        end else if (pre_q == PreW'(TicksPerMs - 1)) begin
            pre_q   <= '0;
            timer_q <= timer_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end
`endif

    // Combinational read mux
    always_comb begin
        io.io_data_in = 16'h0000;
        case (addr)
            14'h0000: io.io_data_in = led_q;
            14'h0001: io.io_data_in = sw_sync_q;
            14'h0003: io.io_data_in = {12'b0, ovf_q, busy, empty, full};
`ifdef IO_TIMER_EN
            14'h0004: io.io_data_in = timer_q;
`endif
            default:  io.io_data_in = 16'h0000;
        endcase
    end

    assign led_o = led_q;
endmodule

// File: tb/tb_mmio_io_responder.sv
// Bench for mmio_io_responder: random traffic against a line-level UART receiver model,
// an expected-byte queue and per-register expectations.
module tb_mmio_io_responder;
    localparam int unsigned ClkHz = 1_000_000;
    localparam int unsigned Baud  = 100_000;
    localparam int unsigned Cpb   = ClkHz / Baud;
    localparam int unsigned Frame = 10 * Cpb + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw_i = 16'hFFFF;
    logic [15:0] led_o;
    logic        uart_txd_o;

    mmio_io_if bus ();

    mmio_io_responder #(
        .CLK_HZ    (ClkHz),
        .BAUD      (Baud),
        .FIFO_DEPTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .io        (bus),
        .sw_i      (sw_i),
        .led_o     (led_o),
        .uart_txd_o(uart_txd_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [15:0] led_model;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        bus.io_addr = a;
        #1;
        d = bus.io_data_in;
    endtask

    task automatic chk_reg(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    // Drives one write; returns 1ns after the committing edge
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.io_addr     = a;
        bus.io_data_out = d;
        bus.io_we       = 1'b1;
        @(posedge clk);
        #1;
        bus.io_we = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        int n   = exp_q.size();
        while (rx_q.size() < n && cyc < n * Frame + 50 * Cpb) begin
            @(posedge clk);
            cyc++;
        end
        check({tag, "_rx_count"}, 16'(rx_q.size()), 16'(n));
        while (exp_q.size() > 0 && rx_q.size() > 0)
            check({tag, "_rx_byte"}, {8'h00, rx_q.pop_front()}, {8'h00, exp_q.pop_front()});
        exp_q.delete();
        rx_q.delete();
    endtask

    // Line-level receiver: samples mid-bit, drops any frame that overlaps a reset
    logic [7:0] rx_byte;
    bit         rx_abort;
    initial begin
        forever begin
            @(negedge uart_txd_o);
            rx_abort = rst;
            repeat (Cpb / 2) @(posedge clk);
            #1;
            if (rst) rx_abort = 1;
            for (int i = 0; i < 8; i++) begin
                repeat (Cpb) @(posedge clk);
                #1;
                if (rst) rx_abort = 1;
                rx_byte[i] = uart_txd_o;
            end
            repeat (Cpb) @(posedge clk);
            #1;
            if (rst) rx_abort = 1;
            if (!rx_abort) begin
                check("rx_stop_bit", {15'b0, uart_txd_o}, 16'h0001);
                rx_q.push_back(rx_byte);
            end
        end
    end

    initial begin
        logic [15:0] d;
        logic [7:0]  b;
        logic [9:0]  frame;
        logic [1:0]  top;
        int          cur;
        bit          low_seen;

        bus.io_addr = '0;
        bus.io_data_out = '0;
        bus.io_we = 1'b0;

        // Reset state with switches high
        cycles(4);
        check("rst_led", led_o, 16'h0000);
        check("rst_txd", {15'b0, uart_txd_o}, 16'h0001);
        chk_reg("rst_status", 16'h0003, 16'h0002);
        @(negedge clk);
        rst = 1'b0;
        chk_reg("rst_sw_sync", 16'h0001, 16'h0000);

        // LED write and readback
        wr(16'h0000, 16'hA5C3);
        led_model = 16'hA5C3;
        check("led_pin", led_o, led_model);
        chk_reg("led_read", 16'h0000, led_model);

        // Switch synchronizer latency
        cycles(3);
        sw_i = 16'h1234;
        chk_reg("sw_before", 16'h0001, 16'hFFFF);
        cycles(1);
        chk_reg("sw_one_clk", 16'h0001, 16'hFFFF);
        cycles(1);
        chk_reg("sw_two_clk", 16'h0001, 16'h1234);

        // Single frame with exact bit timing
        wr(16'h0002, 16'hFF55);
        exp_q.push_back(8'h55);
        check("frame_idle_txd", {15'b0, uart_txd_o}, 16'h0001);
        chk_reg("frame_idle_status", 16'h0003, 16'h0000);
        cycles(1);
        check("frame_start_txd", {15'b0, uart_txd_o}, 16'h0000);
        chk_reg("frame_busy_status", 16'h0003, 16'h0006);
        chk_reg("txdata_read", 16'h0002, 16'h0000);
        frame = {1'b1, 8'h55, 1'b0};
        cur = 1;
        for (int i = 0; i < 10; i++) begin
            cycles(1 + i * Cpb + Cpb / 2 - cur);
            cur = 1 + i * Cpb + Cpb / 2;
            check("frame_bit", {15'b0, uart_txd_o}, {15'b0, frame[i]});
        end
        cycles(10 * Cpb - cur);
        chk_reg("frame_stop_busy", 16'h0003, 16'h0006);
        cycles(1);
        chk_reg("frame_done_status", 16'h0003, 16'h0002);
        drain("frame");

        // Fill, overflow and ovf clear while the transmitter is busy
        b = 8'($urandom);
        wr(16'h0002, {8'h00, b});
        exp_q.push_back(b);
        cycles(2);
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            wr(16'h0002, {8'h00, b});
            exp_q.push_back(b);
        end
        chk_reg("fifo_full", 16'h0003, 16'h0005);
        wr(16'h0002, 16'h00EE);
        chk_reg("fifo_ovf", 16'h0003, 16'h000D);
        wr(16'h0003, 16'h0000);
        chk_reg("ovf_clear", 16'h0003, 16'h0005);
        drain("fifo");
        cycles(Cpb);
        chk_reg("fifo_idle", 16'h0003, 16'h0002);

        // Random mixed traffic
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: begin
                    b = 8'($urandom);
                    wr(16'h0002, {8'($urandom), b});
                    exp_q.push_back(b);
                end
                1: begin
                    top = 2'($urandom);
                    d = 16'($urandom);
                    wr({top, 14'h0000}, d);
                    led_model = d;
                    check("rnd_led_pin", led_o, led_model);
                    chk_reg("rnd_led_read", 16'h0000, led_model);
                end
                2: begin
                    top = 2'($urandom);
                    d = {top, 14'($urandom_range(5, 16'h3FFF))};
                    wr(d, 16'($urandom));
                    chk_reg("rnd_unmapped", d, 16'h0000);
                    check("rnd_led_kept", led_o, led_model);
                end
                default: cycles($urandom_range(1, 3 * Cpb));
            endcase
        end
        drain("rnd");

        // Reset in the middle of data bit 4
        b = 8'($urandom) & 8'hEF;
        wr(16'h0002, {8'h00, b});
        cycles(1 + 5 * Cpb + Cpb / 2);
        check("mid_bit4_txd", {15'b0, uart_txd_o}, 16'h0000);
        rst = 1'b1;
        #1;
        check("rst_async_txd", {15'b0, uart_txd_o}, 16'h0001);
        check("rst_led_clear", led_o, 16'h0000);
        cycles(Cpb + 2);
        @(negedge clk);
        rst = 1'b0;
        chk_reg("post_rst_status", 16'h0003, 16'h0002);
        low_seen = 0;
        for (int i = 0; i < 15 * Cpb; i++) begin
            @(posedge clk);
            #1;
            if (uart_txd_o !== 1'b1) low_seen = 1;
        end
        check("no_residual_frame", {15'b0, low_seen}, 16'h0000);
        check("no_residual_rx", 16'(rx_q.size()), 16'h0000);

`ifdef IO_TIMER_EN
        wr(16'h0004, 16'h0000);
        cycles(3 * (ClkHz / 1000) - 1 + Cpb);
        chk_reg("timer_3ms", 16'h0004, 16'h0003);
        wr(16'h0004, 16'h0000);
        chk_reg("timer_clear", 16'h0004, 16'h0000);
`else
        chk_reg("timer_absent", 16'h0004, 16'h0000);
        wr(16'h0004, 16'hBEEF);
        chk_reg("timer_absent_wr", 16'h0004, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
